// File: rtl/cmd_arbiter.sv
// Command sequencer: buffers UART command bytes, arbitrates them against button
// presses, drives stopwatch/watch control pulses and returns an acknowledge byte.
module cmd_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter bit ACK_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       btn_L,
  input  logic       btn_R,
  input  logic       btn_D,
  input  logic       btn_U,
  input  logic [1:0] sw_mode,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       w_inc_hour,
  output logic       w_inc_min,
  output logic       w_inc_sec,
  output logic [3:0] led,
  output logic [1:0] fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_HOUR  = 8'h48;
  localparam logic [7:0] CMD_MIN   = 8'h4D;
  localparam logic [7:0] CMD_SEC   = 8'h53;
  localparam logic [7:0] ACK_BAD   = 8'h3F;

  typedef enum logic [1:0] {IDLE, DISPATCH, ACK_WAIT, ACK_SEND} state_t;

  state_t         state, state_nx;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           overflow;
  logic [7:0]     cmd_reg;

  logic any_btn, fifo_empty, fifo_full, push_req, push, pop;
  logic sw_tgt, dispatching, cmd_valid;
  logic cmd_run, cmd_clr, cmd_hour, cmd_min, cmd_sec;
  logic btn_run, btn_clr, btn_hour, btn_min, btn_sec;

  assign any_btn    = btn_L | btn_R | btn_D | btn_U;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push_req   = rx_done & sw_mode[1];
  // Buttons always win the IDLE slot; the FIFO head waits for a quiet cycle.
  assign pop        = (state == IDLE) & ~any_btn & ~fifo_empty;
  assign push       = push_req & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cmd_reg  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        cmd_reg <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (pop) state_nx = DISPATCH;
      DISPATCH: state_nx = ACK_EN ? ACK_WAIT : IDLE;
      ACK_WAIT: if (!tx_busy) state_nx = ACK_SEND;
      ACK_SEND: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Target is sampled per command at decode time, not when the byte arrived.
  always_comb begin
    sw_tgt      = ~sw_mode[0];
    dispatching = (state == DISPATCH);
    cmd_valid   = sw_tgt ? (cmd_reg == CMD_RUN || cmd_reg == CMD_CLEAR)
                         : (cmd_reg == CMD_HOUR || cmd_reg == CMD_MIN || cmd_reg == CMD_SEC);
    cmd_run     = dispatching &  sw_tgt & (cmd_reg == CMD_RUN);
    cmd_clr     = dispatching &  sw_tgt & (cmd_reg == CMD_CLEAR);
    cmd_hour    = dispatching & ~sw_tgt & (cmd_reg == CMD_HOUR);
    cmd_min     = dispatching & ~sw_tgt & (cmd_reg == CMD_MIN);
    cmd_sec     = dispatching & ~sw_tgt & (cmd_reg == CMD_SEC);
    btn_run     =  sw_tgt & btn_R;
    btn_clr     =  sw_tgt & btn_L;
    btn_hour    = ~sw_tgt & btn_U;
    btn_min     = ~sw_tgt & btn_D;
    btn_sec     = ~sw_tgt & btn_L;
  end

  // Simultaneous button and UART toggles collapse into one toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_run     <= 1'b0;
      sw_clear   <= 1'b0;
      w_inc_hour <= 1'b0;
      w_inc_min  <= 1'b0;
      w_inc_sec  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      sw_run     <= sw_run ^ (btn_run | cmd_run);
      sw_clear   <= (btn_clr | cmd_clr) & ~sw_run;
      w_inc_hour <= btn_hour | cmd_hour;
      w_inc_min  <= btn_min | cmd_min;
      w_inc_sec  <= btn_sec | cmd_sec;
      tx_start   <= (state == ACK_SEND);
      if (dispatching) tx_data <= cmd_valid ? cmd_reg : ACK_BAD;
    end
  end

  assign led       = {overflow, (state == ACK_WAIT) || (state == ACK_SEND), ~fifo_empty, sw_run};
  assign fsm_state = state;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: a negedge monitor checks every output event
// against an expected-event queue filled as stimulus is driven.
module tb_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       btn_L, btn_R, btn_D, btn_U;
  logic [1:0] sw_mode;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start, sw_run, sw_clear, w_inc_hour, w_inc_min, w_inc_sec;
  logic [3:0] led;
  logic [1:0] fsm_state;

  localparam logic [3:0] K_RISE = 4'd1, K_FALL = 4'd2, K_CLR = 4'd3;
  localparam logic [3:0] K_HOUR = 4'd4, K_MIN = 4'd5, K_SEC = 4'd6, K_TX = 4'd7;

  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic        prev_run = 1'b0;
  logic        hold_busy = 1'b0;
  int          busy_cnt = 0;

  cmd_arbiter #(.FIFO_DEPTH(4), .ACK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .btn_L(btn_L), .btn_R(btn_R), .btn_D(btn_D), .btn_U(btn_U),
    .sw_mode(sw_mode), .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .sw_run(sw_run), .sw_clear(sw_clear), .w_inc_hour(w_inc_hour),
    .w_inc_min(w_inc_min), .w_inc_sec(w_inc_sec), .led(led), .fsm_state(fsm_state)
  );

  // Clock and a simple uart_tx stand-in that stays busy after each start.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start)          busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic evt(input logic [11:0] got);
    logic [11:0] e;
    e = 12'hFFF;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("event", {20'h0, got}, {20'h0, e});
  endtask

  task automatic push_exp(input logic [3:0] k, input logic [7:0] d);
    exp_q.push_back({k, d});
  endtask

  always @(negedge clk) begin
    if (rst || !mon_en) prev_run = sw_run;
    else begin
      if (sw_run !== prev_run) evt({sw_run ? K_RISE : K_FALL, 8'h00});
      prev_run = sw_run;
      if (sw_clear)   evt({K_CLR, 8'h00});
      if (w_inc_hour) evt({K_HOUR, 8'h00});
      if (w_inc_min)  evt({K_MIN, 8'h00});
      if (w_inc_sec)  evt({K_SEC, 8'h00});
      if (tx_start) begin
        chk("tx_idle_at_start", {31'h0, tx_busy}, 32'h0);
        evt({K_TX, tx_data});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (40) tick();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {tx_data, tx_start, sw_run, sw_clear, w_inc_hour, w_inc_min, w_inc_sec, led, fsm_state}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
    btn_L = 1'b0; btn_R = 1'b0; btn_D = 1'b0; btn_U = 1'b0;
    sw_mode = 2'b10;
    tick(); tick();
    chk_all_zero("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 'R' starts the stopwatch with the documented latency.
    push_exp(K_RISE, 8'h00); push_exp(K_TX, 8'h52);
    send_byte(8'h52);
    chk("run_at_n", {31'h0, sw_run}, 32'h0);
    tick(); chk("run_at_n1", {31'h0, sw_run}, 32'h0);
    tick(); chk("run_at_n2", {31'h0, sw_run}, 32'h1);
    chk("led0", {31'h0, led[0]}, 32'h1);
    tick(); chk("txs_at_n3", {31'h0, tx_start}, 32'h0);
    tick(); chk("txs_at_n4", {31'h0, tx_start}, 32'h1);
    chk("txd_at_n4", {24'h0, tx_data}, 32'h52);
    wait_empty(200);

    // 'R' then invalid 'X' back to back.
    push_exp(K_FALL, 8'h00); push_exp(K_TX, 8'h52); push_exp(K_TX, 8'h3F);
    send_byte(8'h52);
    send_byte(8'h58);
    wait_empty(300);

    // Clear is suppressed while running, from both sources.
    push_exp(K_RISE, 8'h00); push_exp(K_TX, 8'h52);
    send_byte(8'h52);
    wait_empty(200);
    push_exp(K_TX, 8'h43);
    btn_L = 1'b1; tick(); btn_L = 1'b0;
    send_byte(8'h43);
    wait_empty(200);
    push_exp(K_FALL, 8'h00); push_exp(K_TX, 8'h52);
    push_exp(K_CLR, 8'h00); push_exp(K_TX, 8'h43);
    send_byte(8'h52);
    send_byte(8'h43);
    wait_empty(300);

    // Watch target: H, M, S then a button with no tx traffic.
    sw_mode = 2'b11;
    push_exp(K_HOUR, 8'h00); push_exp(K_TX, 8'h48);
    push_exp(K_MIN, 8'h00);  push_exp(K_TX, 8'h4D);
    push_exp(K_SEC, 8'h00);  push_exp(K_TX, 8'h53);
    send_byte(8'h48); send_byte(8'h4D); send_byte(8'h53);
    wait_empty(400);
    push_exp(K_HOUR, 8'h00);
    btn_U = 1'b1; tick(); btn_U = 1'b0;
    wait_empty(50);

    // Overflow: six 'M' strobes while the transmitter is held busy.
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_exp(K_MIN, 8'h00); push_exp(K_TX, 8'h4D);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h4D);
    repeat (4) tick();
    chk("overflow_led", {28'h0, led}, 32'hE);
    chk("one_in_flight", exp_q.size(), 9);
    hold_busy = 1'b0;
    wait_empty(600);
    chk("overflow_sticky", {31'h0, led[3]}, 32'h1);

    // Button and UART 'R' in the same cycle: two toggles, net stopped.
    sw_mode = 2'b10;
    push_exp(K_RISE, 8'h00); push_exp(K_FALL, 8'h00); push_exp(K_TX, 8'h52);
    btn_R = 1'b1; rx_data = 8'h52; rx_done = 1'b1;
    tick();
    btn_R = 1'b0; rx_done = 1'b0;
    chk("btn_first", {31'h0, sw_run}, 32'h1);
    tick(); chk("uart_pending", {31'h0, sw_run}, 32'h1);
    tick(); chk("uart_toggle", {31'h0, sw_run}, 32'h0);
    wait_empty(200);

    // Reset while waiting for the transmitter drops the acknowledge.
    hold_busy = 1'b1;
    push_exp(K_RISE, 8'h00);
    send_byte(8'h52);
    repeat (4) tick();
    chk("in_ack_wait", {30'h0, fsm_state}, 32'h2);
    chk("ack_pending_led", {31'h0, led[2]}, 32'h1);
    rst = 1'b1;
    tick();
    chk_all_zero("reset_mid_ack");
    tick();
    rst = 1'b0;
    hold_busy = 1'b0;
    wait_empty(100);
    chk("idle_after_reset", {30'h0, fsm_state}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Control sequencer between the UART receiver, the four debounced buttons and the stopwatch/watch datapath in `top`.
- Buffers received command bytes and decodes them. Arbitrates UART against button requests.
- Emits single-cycle control pulses plus a run level to the selected timer, and sends a one-byte acknowledge back through the UART transmitter.
- Sits between the uart_rx/uart_tx pair and the stopwatch/watch cores.

Parameters:
- FIFO_DEPTH, 4, command byte buffer depth; power of two, at least 2.
- ACK_EN, 1, 1 = send an acknowledge byte per UART command; 0 = no acknowledge traffic.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle strobe from uart_rx
- btn_L, btn_R, btn_D, btn_U  in  1 each  debounced one-cycle press pulses
- sw_mode  in  2  [1]=UART commands enabled; [0]=target (0 stopwatch, 1 watch)
- tx_busy  in  1  uart_tx busy
- tx_data  out  8  acknowledge byte
- tx_start  out  1  one-cycle transmit request
- sw_run  out  1  stopwatch run level
- sw_clear  out  1  stopwatch clear pulse
- w_inc_hour, w_inc_min, w_inc_sec  out  1 each  watch increment pulses
- led  out  4  status: [0]=sw_run, [1]=FIFO non-empty, [2]=ack pending, [3]=overflow sticky

Behaviour:
- Reset: all outputs 0, tx_data=8'h00, FIFO empty, overflow flag cleared, FSM in IDLE. A reset mid-transmission-wait drops any pending acknowledge.
- FIFO write:
  - rx_done=1 with sw_mode[1]=1 writes rx_data on that edge.
  - If sw_mode[1]=0 the byte is discarded.
  - Full FIFO: the byte is dropped and led[3] is set; led[3] is cleared only by rst.
  - A write and a pop in the same cycle on a full FIFO is accepted; the count stays at FULL.
- Command map, case-sensitive:
  - Stopwatch target: 'R'(52h) toggles sw_run; 'C'(43h) pulses sw_clear.
  - Watch target: 'H'(48h), 'M'(4Dh), 'S'(53h) pulse w_inc_hour, w_inc_min, w_inc_sec respectively.
  - Any other byte, or a byte not valid for the current target, is invalid: no control pulse.
- Button map:
  - Stopwatch target: btn_R toggles sw_run; btn_L pulses sw_clear.
  - Watch target: btn_U pulses hour, btn_D pulses min, btn_L pulses sec.
  - Unmapped buttons are ignored.
- sw_clear is suppressed while sw_run=1 (clear only when stopped), from both button and UART sources.
- FSM states: IDLE, DISPATCH, ACK_WAIT, ACK_SEND.
  - IDLE, any button pulse present: the button action is applied and its output pulse appears the next cycle. The button always wins. The FIFO is not popped that cycle and the FSM stays in IDLE.
  - IDLE, no button, FIFO non-empty: pop the head into cmd_reg and go to DISPATCH.
  - DISPATCH (1 cycle): drive the decoded pulse or sw_run toggle, registered so it is visible for exactly one cycle.
    - Load tx_data with the command byte if it is valid, else 3Fh ('?').
    - Go to ACK_WAIT if ACK_EN=1, else IDLE.
  - ACK_WAIT: stay while tx_busy=1; go to ACK_SEND when tx_busy=0.
  - ACK_SEND (1 cycle): tx_start=1, then go to IDLE.
- Button pulses arriving outside IDLE are applied immediately, in parallel with the current state. They never block and are never lost.
  - If a button and a DISPATCH hit the same output, the outputs OR.
  - If both toggle sw_run in the same cycle, the net effect is a single toggle.
- Latency: rx_done at edge N; with the FIFO previously empty and the FSM in IDLE, the control pulse or toggle is visible during cycle N+2.
  - With ACK_EN=1 and tx_busy=0, tx_start=1 during cycle N+4.
- A change of sw_mode[0] is sampled at decode time, per command; queued bytes are decoded against the current target.

Test Plan:
- rst pulse, sw_mode=10, send "R" via UART at 9600 baud:
  - sw_run goes 0→1 two cycles after rx_done.
  - tx_start fires once with tx_data=52h.
  - led[0]=1.
- Send "R" then "X", back to back:
  - sw_run returns to 0 after "R".
  - "X" produces no pulse and an acknowledge byte of 3Fh.
  - Two tx_start pulses total, the second only after tx_busy falls.
- sw_run=1, send "C" and press btn_L: no sw_clear pulse. After "R" stops the timer, "C" gives exactly one sw_clear pulse and acknowledge 43h.
- sw_mode=11 (watch), send "H","M","S": one pulse each on w_inc_hour, w_inc_min, w_inc_sec, in that order. Then btn_U: one w_inc_hour pulse, no tx activity.
- Hold tx_busy=1, inject 6 rx_done strobes of 'M' with FIFO_DEPTH=4 in watch mode:
  - led[3]=1.
  - After tx_busy is released, exactly 5 w_inc_min pulses occur (1 in flight plus 4 buffered).
- rx_done coincident with btn_R in stopwatch mode:
  - The button toggle occurs first.
  - The UART 'R' toggles one cycle or more later, so net sw_run returns to 0.
  - Assert rst during ACK_WAIT: all outputs return to 0 next cycle and no tx_start occurs.
